// File: rtl/can_pkg.sv
// Shared CAN 2.0A definitions: field widths, CRC-15 polynomial and the
// frame-field state enumeration used by both transmit and receive paths.
package can_pkg;

    localparam logic [14:0] CRC15_POLY  = 15'h4599;
    localparam int          ID_W        = 11;
    localparam int          DLC_W       = 4;
    localparam int          CRC_W       = 15;
    localparam int          EOF_BITS    = 7;
    localparam int          STUFF_LIMIT = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } can_state_e;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 LFSR, one unstuffed bit per enabled cycle; clear wins over enable.
module can_crc15
    import can_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Clear,
    input  logic             i_En,
    input  logic             i_Bit,
    output logic [CRC_W-1:0] o_Crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        fb    = i_Bit ^ crc_q[CRC_W-1];
        crc_d = {crc_q[CRC_W-2:0], 1'b0};
        if (fb) crc_d = crc_d ^ CRC15_POLY;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear) crc_q <= '0;
        else if (i_En)          crc_q <= crc_d;
    end

    assign o_Crc = crc_q;

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A frame transmitter with CRC-15 and bit stuffing.
// Define CAN_TX_ACK_CHECK_EN to sample i_Rx_Serial in the ACK slot and flag o_Ack_Err.
module can_frame_tx
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int IFS_BITS     = 3
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Tx_DV,
    input  logic [ID_W-1:0]  i_Identifier,
    input  logic             i_RTR,
    input  logic [DLC_W-1:0] i_DLC,
    input  logic [63:0]      i_Data,
    input  logic             i_Rx_Serial,
    output logic             o_Tx_Serial,
    output logic             o_Tx_Active,
    output logic             o_Tx_Done,
    output logic             o_Ack_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    can_state_e       state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [CW-1:0]    clk_q;
    logic [ID_W-1:0]  id_q;
    logic             rtr_q;
    logic [DLC_W-1:0] dlc_q;
    logic [63:0]      data_q;
    logic             tx_q, active_q, done_q, ack_err_q;
    logic             last_q;
    logic [2:0]       run_q;

    logic             bit_d, frame_end, wrap, stuff_due, crc_en, accept;
    logic [3:0]       nbytes;
    logic [6:0]       data_last;
    logic [11:0]      arb_word;
    logic [5:0]       ctrl_word;
    logic [CRC_W-1:0] crc;

    assign wrap      = (clk_q == CW'(CLKS_PER_BIT - 1));
    assign accept    = (state_q == ST_IDLE) && i_Tx_DV;
    assign nbytes    = dlc_q[3] ? 4'd8 : dlc_q;
    assign data_last = {nbytes, 3'b000} - 7'd1;
    assign arb_word  = {id_q, rtr_q};
    assign ctrl_word = {2'b00, dlc_q};
    // state_q/cnt_q track the last field bit sent; a stuff bit leaves them untouched.
    assign stuff_due = (state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC})
                       && (run_q == 3'(STUFF_LIMIT));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 7'd1;
        frame_end = 1'b0;
        case (state_q)
            ST_SOF:     begin state_d = ST_ARB; cnt_d = '0; end
            ST_ARB:     if (cnt_q == 7'd11) begin state_d = ST_CTRL; cnt_d = '0; end
            ST_CTRL:    if (cnt_q == 7'd5) begin
                            state_d = (rtr_q || dlc_q == '0) ? ST_CRC : ST_DATA;
                            cnt_d   = '0;
                        end
            ST_DATA:    if (cnt_q == data_last) begin state_d = ST_CRC; cnt_d = '0; end
            ST_CRC:     if (cnt_q == 7'd14) begin state_d = ST_CRC_DEL; cnt_d = '0; end
            ST_CRC_DEL: begin state_d = ST_ACK; cnt_d = '0; end
            ST_ACK:     begin state_d = ST_ACK_DEL; cnt_d = '0; end
            ST_ACK_DEL: begin state_d = ST_EOF; cnt_d = '0; end
            ST_EOF:     if (cnt_q == 7'(EOF_BITS - 1)) begin state_d = ST_IFS; cnt_d = '0; end
            ST_IFS:     if (cnt_q == 7'(IFS_BITS - 1)) begin
                            state_d   = ST_IDLE;
                            cnt_d     = '0;
                            frame_end = 1'b1;
                        end
            default:    cnt_d = '0;
        endcase
        case (state_d)
            ST_ARB:  bit_d = arb_word[4'd11 - cnt_d[3:0]];
            ST_CTRL: bit_d = ctrl_word[3'd5 - cnt_d[2:0]];
            ST_DATA: bit_d = data_q[6'd63 - cnt_d[5:0]];
            ST_CRC:  bit_d = crc[4'd14 - cnt_d[3:0]];
            default: bit_d = 1'b1;
        endcase
    end

    // The SOF bit is 0 into a zeroed register, a no-op, so the CRC only needs ARB onward.
    assign crc_en = (state_q != ST_IDLE) && wrap && !stuff_due
                    && (state_d inside {ST_ARB, ST_CTRL, ST_DATA});

    can_crc15 u_crc (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Clear (accept),
        .i_En    (crc_en),
        .i_Bit   (bit_d),
        .o_Crc   (crc)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clk_q     <= '0;
            id_q      <= '0;
            rtr_q     <= 1'b0;
            dlc_q     <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            last_q    <= 1'b0;
            run_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                clk_q <= '0;
                if (i_Tx_DV) begin
                    id_q      <= i_Identifier;
                    rtr_q     <= i_RTR;
                    dlc_q     <= i_DLC;
                    data_q    <= i_Data;
                    state_q   <= ST_SOF;
                    cnt_q     <= '0;
                    tx_q      <= 1'b0;
                    active_q  <= 1'b1;
                    ack_err_q <= 1'b0;
                    last_q    <= 1'b0;
                    run_q     <= 3'd1;
                end
            end else begin
`ifdef CAN_TX_ACK_CHECK_EN
                if (state_q == ST_ACK && clk_q == CW'(CLKS_PER_BIT / 2) && i_Rx_Serial)
                    ack_err_q <= 1'b1;
`endif
                if (wrap) begin
                    clk_q <= '0;
                    if (stuff_due) begin
                        tx_q   <= ~last_q;
                        last_q <= ~last_q;
                        run_q  <= 3'd1;
                    end else begin
                        state_q <= state_d;
                        cnt_q   <= cnt_d;
                        tx_q    <= bit_d;
                        if (state_d inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC}) begin
                            run_q  <= (bit_d == last_q) ? run_q + 3'd1 : 3'd1;
                            last_q <= bit_d;
                        end
                        if (frame_end) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end else begin
                    clk_q <= clk_q + CW'(1);
                end
            end
        end
    end

`ifndef CAN_TX_ACK_CHECK_EN
    logic unused_rx;
    assign unused_rx = i_Rx_Serial;
`endif

    assign o_Tx_Serial = tx_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Ack_Err   = ack_err_q;

endmodule
